// File: rtl/sa2_pkg.sv
// Shared types and sizes for the 2x2 convolution array sequencer.
package sa2_pkg;
    localparam int SA2_N_A = 16;
    localparam int SA2_N_B = 9;
    localparam int SA2_N_C = 4;
    localparam int SA2_W   = 8;

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} sa2_state_e;
    typedef logic [SA2_W-1:0] sa2_byte_t;
endpackage

// File: rtl/sa2_conv_sequencer_if.sv
// Host byte streams plus array operand/result wiring for the sequencer.
interface sa2_conv_sequencer_if;
    import sa2_pkg::*;

    logic      in_valid, in_ready, out_valid, out_ready;
    sa2_byte_t in_data, out_data;
    sa2_byte_t a11, a12, a13, a14, a21, a22, a23, a24;
    sa2_byte_t a31, a32, a33, a34, a41, a42, a43, a44;
    sa2_byte_t b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic      active_sa2, done_sa2, err;
    sa2_byte_t c11, c12, c21, c22;

    modport slave (
        input  in_valid, in_data, out_ready, done_sa2, c11, c12, c21, c22,
        output in_ready, out_valid, out_data, active_sa2, err,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33
    );

    modport master (
        output in_valid, in_data, out_ready, done_sa2, c11, c12, c21, c22,
        input  in_ready, out_valid, out_data, active_sa2, err,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33
    );
endinterface

// File: rtl/sa2_result_serializer.sv
// Four-entry result buffer drained one byte at a time over valid/ready.
module sa2_result_serializer
    import sa2_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [SA2_N_C-1:0][SA2_W-1:0] data_i,
    output logic                          out_valid_o,
    output logic [SA2_W-1:0]              out_data_o,
    input  logic                          out_ready_i,
    output logic                          last_o
);
    localparam int JW = $clog2(SA2_N_C);

    logic [SA2_N_C-1:0][SA2_W-1:0] res_q;
    logic [JW-1:0]                 j_q;
    logic                          valid_q;
    logic                          xfer;

    assign xfer        = valid_q && out_ready_i;
    assign last_o      = xfer && (j_q == JW'(SA2_N_C - 1));
    assign out_valid_o = valid_q;
    assign out_data_o  = res_q[j_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            res_q   <= data_i;
            j_q     <= '0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            // j wraps back to 0 on the last entry
            j_q <= j_q + JW'(1);
            if (last_o) valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/sa2_conv_sequencer.sv
// Loads 25 operand bytes, runs the 2x2 systolic array until done or timeout,
// then streams the four results back.
//   state | meaning
//   LOAD  | accepting operand bytes into a/b registers
//   RUN   | active_sa2 high, waiting for done_sa2 or timeout
//   DRAIN | result serializer emitting c11, c12, c21, c22
module sa2_conv_sequencer
    import sa2_pkg::*;
#(
    parameter int TIMEOUT = 63
) (
    input logic                 clk,
    input logic                 rst,
    sa2_conv_sequencer_if.slave bus
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    sa2_state_e                    state_q;
    logic [4:0]                    k_q;
    logic [TW-1:0]                 t_q;
    logic [SA2_N_A-1:0][SA2_W-1:0] a_q;
    logic [SA2_N_B-1:0][SA2_W-1:0] b_q;
    logic                          in_ready_q, active_q, err_q;
    logic                          in_xfer, done_run, timeout_run, res_load, drain_last;
    logic [SA2_N_C-1:0][SA2_W-1:0] res_d;

    assign in_xfer     = bus.in_valid && in_ready_q;
    assign done_run    = (state_q == RUN) && bus.done_sa2;
    assign timeout_run = (state_q == RUN) && !bus.done_sa2 && (t_q == TW'(TIMEOUT));
    assign res_load    = done_run || timeout_run;
    assign res_d       = done_run ? {bus.c22, bus.c21, bus.c12, bus.c11} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            k_q        <= '0;
            t_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b1;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (in_xfer) begin
                    // k[4] splits feature bytes (0..15) from kernel bytes (16..24)
                    if (!k_q[4]) a_q[k_q[3:0]] <= bus.in_data;
                    else         b_q[k_q[3:0]] <= bus.in_data;
                    if (k_q == 5'd24) begin
                        k_q        <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        active_q   <= 1'b1;
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                RUN: begin
                    t_q <= t_q + TW'(1);
                    if (res_load) begin
                        state_q  <= DRAIN;
                        active_q <= 1'b0;
                    end
                    if (timeout_run) err_q <= 1'b1;
                end
                DRAIN: if (drain_last) begin
                    t_q        <= '0;
                    state_q    <= LOAD;
                    in_ready_q <= 1'b1;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    sa2_result_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (res_load),
        .data_i     (res_d),
        .out_valid_o(bus.out_valid),
        .out_data_o (bus.out_data),
        .out_ready_i(bus.out_ready),
        .last_o     (drain_last)
    );

    assign bus.in_ready   = in_ready_q;
    assign bus.active_sa2 = active_q;
    assign bus.err        = err_q;
    assign {bus.a44, bus.a43, bus.a42, bus.a41, bus.a34, bus.a33, bus.a32, bus.a31,
            bus.a24, bus.a23, bus.a22, bus.a21, bus.a14, bus.a13, bus.a12, bus.a11} = a_q;
    assign {bus.b33, bus.b32, bus.b31, bus.b23, bus.b22, bus.b21,
            bus.b13, bus.b12, bus.b11} = b_q;
endmodule

// File: doc/sa2_conv_sequencer.md
# sa2_conv_sequencer

Initiator-side sequencer for the 2x2 convolution systolic array. It accepts a 4x4 feature map and a 3x3 kernel as a byte stream and holds them stable on the array's operand ports. It then drives `active_sa2` until the array raises `done_sa2`, captures the four results, and returns them as a byte stream. It sits between the host byte interface and `systolic_array_2_by_2` and replaces bench-style hand driving of `active_sa2`.

## Interface
Parameters:
- `TIMEOUT`, default 63: maximum number of RUN cycles to wait for `done_sa2` before aborting.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input byte is valid.
- `in_data`  in  8  operand byte: 16 feature bytes row-major, then 9 kernel bytes row-major.
- `in_ready`  out  1  sequencer accepts a byte this cycle.
- `a11`..`a44`  out  8 each  feature-map registers to the array.
- `b11`..`b33`  out  8 each  kernel registers to the array.
- `active_sa2`  out  1  run request to the array.
- `done_sa2`  in  1  array completion pulse; results are valid in the same cycle.
- `c11`, `c12`, `c21`, `c22`  in  8 each  array results.
- `out_valid`  out  1  result byte is valid.
- `out_data`  out  8  result byte, in order c11, c12, c21, c22.
- `out_ready`  in  1  downstream accepts the result byte.
- `err`  out  1  sticky timeout flag, cleared only by `rst`.

## Operation
- States: LOAD, RUN, DRAIN.
- **LOAD**
  - `in_ready`=1.
  - A byte transfers when `in_valid`&&`in_ready`; a 5-bit count `k` increments on each transfer.
  - k=0..15 write `a[k/4+1][k%4+1]`; k=16..24 write `b[(k-16)/3+1][(k-16)%3+1]`.
  - On the transfer with k=24: clear `k` and go to RUN.
- **RUN**
  - `in_ready`=0, `active_sa2`=1, and a cycle counter `t` increments every cycle.
  - Operand registers are frozen.
  - Cycle where `done_sa2`=1: capture c11..c22 into a 4x8 result buffer and go to DRAIN.
  - Otherwise, if `t`==TIMEOUT: set `err`, load zeros into the result buffer and go to DRAIN.
- **DRAIN**
  - `out_valid`=1 and `out_data`=buffer[j], with j=0..3.
  - j advances on `out_valid`&&`out_ready`.
  - On the transfer with j=3: clear j and `t`, and go to LOAD.
- Result ordering is fixed: c11, c12, c21, c22.
- All arithmetic is unsigned 8-bit; the sequencer never modifies values.
- `done_sa2` outside RUN is ignored.
- `in_valid` outside LOAD is ignored, and no byte is consumed.
- Operand registers keep their last values after a run; a new LOAD overwrites all 25.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge):
  - state=LOAD; k, j, t=0; all a/b registers=0; result buffer=0.
  - Outputs: `err`=0, `active_sa2`=0, `out_valid`=0, `in_ready`=1 on the cycle after reset.
- Reset mid-operation, in any state, aborts the run. `active_sa2` drops on the next cycle and partial loads or results are discarded.
- `active_sa2` is registered.
  - It rises on the cycle after the 25th byte is accepted.
  - It falls on the cycle after `done_sa2` is sampled high, so it is high for N+1 cycles, where N is the array latency from the first active cycle.
- `out_valid` rises on the cycle after `done_sa2` is sampled.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` returns to 1 on the cycle after the 4th result transfer.
- Minimum back-to-back throughput is 25 + (N+1) + 4 cycles per convolution.
- `done_sa2` and timeout on the same cycle: `done_sa2` wins and `err` stays unchanged.

## Structure
- Shared package `sa2_pkg` holds:
  - the state enum (LOAD, RUN, DRAIN);
  - `SA2_N_A`=16, `SA2_N_B`=9, `SA2_N_C`=4;
  - `SA2_W`=8.
- One sub-module is natural: `sa2_result_serializer`. It is a 4-entry buffer with a load strobe and a valid/ready output, handling the DRAIN counter and output hold.
- The operand register file and load counter stay in the top module.

## Test plan
- Array stub asserts `done_sa2` 28 cycles after `active_sa2` rises, with c=192/237/116/161. Stream bytes 1..16 then 1..9 with `in_valid` held high; hold `out_ready`=1.
  - Expect a11=1, a44=16, b11=1, b33=9 frozen during RUN.
  - Expect `active_sa2` high 29 cycles.
  - Expect outputs 192, 237, 116, 161 in order, and `err`=0.
- Input backpressure: drop `in_valid` randomly during the same load. Expect identical register contents and `active_sa2` only after the 25th accepted byte.
- Output backpressure: hold `out_ready`=0 for 5 cycles on the 2nd result. Expect `out_data`=237 held for those cycles, then 116 and 161, then `in_ready`=1.
- Timeout: the stub never asserts `done_sa2`, with TIMEOUT=63.
  - Expect `err`=1 after 64 RUN cycles.
  - Expect four 0 output bytes, then a return to LOAD.
  - `err` stays 1 through a subsequent good run.
- Reset mid-RUN: assert `rst` 10 cycles into RUN.
  - Expect `active_sa2`=0 and all operands 0 on the next cycle, with `in_ready`=1.
  - A fresh 25-byte load then runs normally.
- Spurious `done_sa2` during LOAD and extra `in_valid` during RUN/DRAIN: expect no state change and no consumed bytes.
